// File: rtl/bcd_clock_pkg.sv
// Shared types and digit/hour limits for the BCD time-of-day counter.
package bcd_clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t LS_MAX   = 4'd9;
    localparam bcd_digit_t MS_MAX   = 4'd5;
    localparam logic [7:0] HR24_MAX = 8'd23;
    localparam logic [7:0] HR12_MIN = 8'd1;
    localparam logic [7:0] HR12_MAX = 8'd12;

    // Binary value of a two-digit BCD pair; out-of-range digits still yield a usable magnitude.
    function automatic logic [7:0] bcd_pair_value(input bcd_digit_t ms, input bcd_digit_t ls);
        return ({4'd0, ms} * 8'd10) + {4'd0, ls};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register with load, clear and increment-with-wrap against a runtime limit.
module bcd_digit
    import bcd_clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  bcd_digit_t max,
    output bcd_digit_t q,
    output logic       wrap
);

    // >= rather than == so an illegal loaded value still carries out on its next increment
    assign wrap = inc && (q >= max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= wrap ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_clock_counter.sv
// Loadable BCD time-of-day counter, 24h or 12h (AM/PM), with day rollover and load validation.
// Seconds digits and ports exist only when BCD_CLOCK_SECONDS_EN is defined.
module bcd_clock_counter
    import bcd_clock_pkg::*;
#(
    parameter int H12_MODE   = 0,
    parameter int LOAD_CHECK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  bcd_digit_t new_ms_hr,
    input  bcd_digit_t new_ls_hr,
    input  bcd_digit_t new_ms_min,
    input  bcd_digit_t new_ls_min,
`ifdef BCD_CLOCK_SECONDS_EN
    input  bcd_digit_t new_ms_sec,
    input  bcd_digit_t new_ls_sec,
`endif
    input  logic       new_pm,
    output bcd_digit_t ms_hr,
    output bcd_digit_t ls_hr,
    output bcd_digit_t ms_min,
    output bcd_digit_t ls_min,
`ifdef BCD_CLOCK_SECONDS_EN
    output bcd_digit_t ms_sec,
    output bcd_digit_t ls_sec,
`endif
    output logic       pm,
    output logic       day_pulse,
    output logic       load_err
);

    localparam bit         IS_H12    = (H12_MODE != 0);
    localparam bcd_digit_t RST_MS_HR = IS_H12 ? 4'd1 : 4'd0;
    localparam bcd_digit_t RST_LS_HR = IS_H12 ? 4'd2 : 4'd0;

    logic       adv;
    logic       digits_ok;
    logic       hr_ok;
    logic       load_ok;
    logic       min_adv;
    logic       ls_min_wrap;
    logic       hr_adv;
    logic [7:0] new_hr_val;
    logic [7:0] hr_val;

    // A load always wins; a tick arriving with any load (accepted or rejected) is dropped.
    assign adv        = tick & ~load;
    assign new_hr_val = bcd_pair_value(new_ms_hr, new_ls_hr);
    assign hr_val     = bcd_pair_value(ms_hr, ls_hr);

    always_comb begin
        digits_ok = (new_ls_hr <= LS_MAX) && (new_ls_min <= LS_MAX) && (new_ms_min <= MS_MAX);
`ifdef BCD_CLOCK_SECONDS_EN
        digits_ok = digits_ok && (new_ls_sec <= LS_MAX) && (new_ms_sec <= MS_MAX);
`endif
        if (IS_H12) begin
            hr_ok = (new_hr_val >= HR12_MIN) && (new_hr_val <= HR12_MAX);
        end else begin
            hr_ok = (new_hr_val <= HR24_MAX);
        end
    end

    assign load_ok = load && ((LOAD_CHECK == 0) || (digits_ok && hr_ok));

`ifdef BCD_CLOCK_SECONDS_EN
    logic ls_sec_wrap;

    bcd_digit u_ls_sec (
        .clk(clk), .reset(reset), .inc(adv), .clr(1'b0), .ld(load_ok),
        .ld_val(new_ls_sec), .max(LS_MAX), .q(ls_sec), .wrap(ls_sec_wrap)
    );

    bcd_digit u_ms_sec (
        .clk(clk), .reset(reset), .inc(ls_sec_wrap), .clr(1'b0), .ld(load_ok),
        .ld_val(new_ms_sec), .max(MS_MAX), .q(ms_sec), .wrap(min_adv)
    );
`else
    assign min_adv = adv;
`endif

    bcd_digit u_ls_min (
        .clk(clk), .reset(reset), .inc(min_adv), .clr(1'b0), .ld(load_ok),
        .ld_val(new_ls_min), .max(LS_MAX), .q(ls_min), .wrap(ls_min_wrap)
    );

    bcd_digit u_ms_min (
        .clk(clk), .reset(reset), .inc(ls_min_wrap), .clr(1'b0), .ld(load_ok),
        .ld_val(new_ms_min), .max(MS_MAX), .q(ms_min), .wrap(hr_adv)
    );

    // Hour pair kept here: its limits depend on the 12/24 mode and it owns pm and day_pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_hr     <= RST_MS_HR;
            ls_hr     <= RST_LS_HR;
            pm        <= 1'b0;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            day_pulse <= 1'b0;
            load_err  <= load & ~load_ok;
            if (load_ok) begin
                ms_hr <= new_ms_hr;
                ls_hr <= new_ls_hr;
                pm    <= IS_H12 & new_pm;
            end else if (hr_adv) begin
                if (!IS_H12) begin
                    if (hr_val >= HR24_MAX) begin
                        ms_hr     <= 4'd0;
                        ls_hr     <= 4'd0;
                        day_pulse <= 1'b1;
                    end else if (ls_hr >= LS_MAX) begin
                        ms_hr <= ms_hr + 4'd1;
                        ls_hr <= 4'd0;
                    end else begin
                        ls_hr <= ls_hr + 4'd1;
                    end
                end else begin
                    if (hr_val >= HR12_MAX) begin
                        ms_hr <= 4'd0;
                        ls_hr <= bcd_digit_t'(HR12_MIN);
                    end else if (hr_val == (HR12_MAX - 8'd1)) begin
                        // 11 -> 12 flips AM/PM; only the PM -> AM flip is a new day
                        ms_hr     <= 4'd1;
                        ls_hr     <= 4'd2;
                        pm        <= ~pm;
                        day_pulse <= pm;
                    end else if (ls_hr >= LS_MAX) begin
                        ms_hr <= ms_hr + 4'd1;
                        ls_hr <= 4'd0;
                    end else begin
                        ls_hr <= ls_hr + 4'd1;
                    end
                end
            end
        end
    end

endmodule
